sorter: RTL and testbench
=========================

// Module: sorter
// PURPOSE
//   Sorts eight unsigned 8-bit values, presented as one packed 64-bit word, into
//   ascending order with a fixed 19-comparator Batcher odd-even merge network.
//   A new set is accepted every clock. The registered result appears one cycle later.
//   Stand-alone datapath block: no handshake, no stall, one clock domain.
// PARAMETERS
//   WIDTH   8   bits per element; unsigned compare; total bus width is 8*WIDTH
//   (element count is fixed at 8; it is not a parameter)
// PORTS
//   clk      in   1         single clock; all state updates on its rising edge
//   rst      in   1         asynchronous, active-high reset
//   sortIn   in   8*WIDTH   packed input; element i = sortIn[WIDTH*i +: WIDTH], i=0..7
//   sortOut  out  8*WIDTH   packed sorted output; lane 0 = minimum, lane 7 = maximum
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Reset: while rst=1, sortOut=0 immediately, independent of clk.
//     The first update occurs on the first rising clk edge after rst deasserts.
//   - Latency 1 cycle, throughput 1 set per cycle:
//     - The network between sortIn and the output register is combinational.
//     - On each rising clk edge with rst=0, sortOut <= sort(sortIn).
//     - sortOut holds its value between edges.
//   - Ordering:
//     - sortOut lane k <= lane k+1 for k=0..6, by unsigned compare.
//     - sortOut is a permutation of the 8 input lanes.
//     - Duplicates are preserved, so the multiset is kept.
//     - Stability is not required, since equal values are indistinguishable.
//   - Compare-exchange rule for pair (a,b): lo = (a<=b) ? a : b; hi = the other.
//     lo moves to the lower lane index.
//   - Network: Batcher odd-even merge sort for 8 lanes, 6 levels, 19 comparators:
//     - L1 (0,1)(2,3)(4,5)(6,7)
//     - L2 (0,2)(1,3)(4,6)(5,7)
//     - L3 (1,2)(5,6)
//     - L4 (0,4)(1,5)(2,6)(3,7)
//     - L5 (2,4)(3,5)
//     - L6 (1,2)(3,4)(5,6)
//   - Boundary cases:
//     - All-equal input passes unchanged.
//     - Already-sorted input passes unchanged.
//     - Reverse-sorted input is fully reversed.
//     - Values 0 and 2^WIDTH-1 are handled correctly; there is no signed interpretation.
//   - X/undefined inputs are not required to be handled. No other outputs, flags, or state.
//   - Reset asserted mid-stream: output goes to 0 at once and in-flight data is discarded.
// STRUCTURE
//   - Shared package: localparam N_ELEM=8; the comparator-pair table above as
//     constants (so the testbench can reuse it); a function to pack/unpack lanes.
//   - One sub-module, cmp_swap #(WIDTH): inputs a,b; outputs lo,hi; purely combinational.
//   - sorter instantiates 19 cmp_swap cells in 6 levels plus a single 8*WIDTH-bit
//     output register with async reset.
//   - No intermediate pipeline registers.
// TESTING
//   1. Reset:
//      - Assert rst with sortIn = 0xFFEEDDCCBBAA9988.
//      - Required: sortOut == 0 with no clock edge needed.
//      - Required: it stays 0 across edges while rst=1.
//   2. Reverse order:
//      - Apply lanes 0..7 = 8,7,6,5,4,3,2,1, i.e. sortIn = 0x0102030405060708.
//      - Required: after one edge, sortOut == 0x0807060504030201 (lane0=1 ... lane7=8).
//   3. Duplicates and extremes:
//      - Apply lanes 0..7 = 255,0,17,17,255,0,128,1.
//      - Required: lanes 0..7 = 0,0,1,17,17,128,255,255 after one edge.
//   4. Back-to-back sets:
//      - Change sortIn every cycle with sets A, B, C.
//      - Required: sortOut shows sort(A), sort(B), sort(C) on consecutive edges,
//        each one cycle after its input.
//   5. Mid-stream reset:
//      - Pulse rst between two edges while data is flowing.
//      - Required: sortOut drops to 0 asynchronously.
//      - Required: the next edge after release loads sort(current sortIn).
//   6. Random:
//      - Apply >=10000 random sets ($urandom%256 per lane).
//      - Required: the output is nondecreasing by lane and is a permutation of the input,
//        checked against a software sort one cycle later.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared constants for the 8-lane sorting network: lane count, the Batcher
// odd-even merge comparator table, and lane addressing helpers.
package sorter_pkg;

  localparam int N_ELEM  = 8;
  localparam int N_LEVEL = 6;
  localparam int N_CMP   = 19;

  // Comparator table: entry c exchanges lanes CMP_A[c] < CMP_B[c] at level CMP_LVL[c].
  localparam int CMP_LVL [N_CMP] = '{0, 0, 0, 0,
                                     1, 1, 1, 1,
                                     2, 2,
                                     3, 3, 3, 3,
                                     4, 4,
                                     5, 5, 5};
  localparam int CMP_A   [N_CMP] = '{0, 2, 4, 6,
                                     0, 1, 4, 5,
                                     1, 5,
                                     0, 1, 2, 3,
                                     2, 3,
                                     1, 3, 5};
  localparam int CMP_B   [N_CMP] = '{1, 3, 5, 7,
                                     2, 3, 6, 7,
                                     2, 6,
                                     4, 5, 6, 7,
                                     4, 5,
                                     2, 4, 6};

  // Bit offset of lane idx inside a packed bus of width-bit lanes.
  function automatic int lane_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  // True when lane idx is touched by some comparator at level lvl.
  function automatic bit lane_busy(input int lvl, input int idx);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < N_CMP; c++) begin
      if (CMP_LVL[c] == lvl && (CMP_A[c] == idx || CMP_B[c] == idx)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Extract one 8-bit lane from a packed 64-bit word.
  function automatic logic [7:0] unpack_lane8(input logic [8*N_ELEM-1:0] bus, input int idx);
    return bus[idx*8 +: 8];
  endfunction

  // Insert one 8-bit lane into a packed 64-bit word.
  function automatic logic [8*N_ELEM-1:0] pack_lane8(input logic [8*N_ELEM-1:0] bus,
                                                     input int idx,
                                                     input logic [7:0] val);
    logic [8*N_ELEM-1:0] r;
    r = bus;
    r[idx*8 +: 8] = val;
    return r;
  endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// Unsigned compare-exchange cell: the smaller value leaves on lo, the larger on hi.
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic a_le_b;

  // Ties keep a on the low side; equal values are indistinguishable anyway.
  always_comb begin
    a_le_b = (a <= b);
    lo     = a_le_b ? a : b;
    hi     = a_le_b ? b : a;
  end

endmodule

// File: rtl/sorter.sv
// Eight-lane ascending sorter: a combinational 19-comparator Batcher odd-even
// merge network feeding a single output register. One set in per clock,
// sorted result one cycle later; lane 0 holds the minimum.
module sorter
  import sorter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_ELEM*WIDTH-1:0] sortIn,
  output logic [N_ELEM*WIDTH-1:0] sortOut
);

  localparam int BUS_W = N_ELEM * WIDTH;

  logic [BUS_W-1:0] sorted_p0;

  // Stage p0: six comparator levels, purely combinational.
  for (genvar gl = 0; gl < N_LEVEL; gl++) begin : g_lvl
    logic [BUS_W-1:0] in_v;
    logic [BUS_W-1:0] out_v;

    if (gl == 0) begin : g_src_in
      assign in_v = sortIn;
    end else begin : g_src_prev
      assign in_v = g_lvl[gl-1].out_v;
    end

    for (genvar gc = 0; gc < N_CMP; gc++) begin : g_cmp
      if (CMP_LVL[gc] == gl) begin : g_cell
        cmp_swap #(.WIDTH(WIDTH)) u_cmp (
          .a  (in_v [lane_lsb(CMP_A[gc], WIDTH) +: WIDTH]),
          .b  (in_v [lane_lsb(CMP_B[gc], WIDTH) +: WIDTH]),
          .lo (out_v[lane_lsb(CMP_A[gc], WIDTH) +: WIDTH]),
          .hi (out_v[lane_lsb(CMP_B[gc], WIDTH) +: WIDTH])
        );
      end
    end

    for (genvar gk = 0; gk < N_ELEM; gk++) begin : g_pass
      if (!lane_busy(gl, gk)) begin : g_wire
        assign out_v[lane_lsb(gk, WIDTH) +: WIDTH] = in_v[lane_lsb(gk, WIDTH) +: WIDTH];
      end
    end
  end

  assign sorted_p0 = g_lvl[N_LEVEL-1].out_v;

  // Stage p0 -> p1: output register, cleared asynchronously so reset discards in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sortOut <= '0;
    end else begin
      sortOut <= sorted_p0;
    end
  end

endmodule

// File: tb/tb_sorter.sv
// Directed and random checks for the 8-lane sorter: reset behaviour, fixed
// vectors with hand-computed results, back-to-back sets, mid-stream reset,
// and random sets compared against a bubble-sort reference.
module tb_sorter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] sortIn = '0;
  logic [63:0] sortOut;

  int checks = 0;
  int errors = 0;

  sorter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .sortIn  (sortIn),
    .sortOut (sortOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%016h exp=%016h", tag, got, exp);
    end
  endtask

  // Reference: plain bubble sort over the eight byte lanes.
  function automatic logic [63:0] sw_sort(input logic [63:0] v);
    logic [7:0]  a [8];
    logic [7:0]  t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  logic [63:0] vec_in  [3];
  logic [63:0] vec_exp [3];
  logic [63:0] rnd;

  initial begin
    // Reset asserted before any clock edge.
    #2;
    sortIn = 64'hFFEEDDCCBBAA9988;
    rst    = 1'b1;
    #1;
    chk("reset_async", sortOut, 64'h0);
    @(posedge clk); #1;
    chk("reset_hold_edge1", sortOut, 64'h0);
    @(posedge clk); #1;
    chk("reset_hold_edge2", sortOut, 64'h0);

    // Release and apply reverse-ordered lanes.
    rst    = 1'b0;
    sortIn = 64'h0102030405060708;
    @(posedge clk); #1;
    chk("reverse", sortOut, 64'h0807060504030201);

    // Duplicates and extremes: lanes 255,0,17,17,255,0,128,1.
    sortIn = 64'h018000FF111100FF;
    @(posedge clk); #1;
    chk("dup_extreme", sortOut, 64'hFFFF801111010000);

    // Back-to-back sets A, B, C.
    vec_in[0]  = 64'h0001020304050607; vec_exp[0] = 64'h0706050403020100;
    vec_in[1]  = 64'h5A5A5A5A5A5A5A5A; vec_exp[1] = 64'h5A5A5A5A5A5A5A5A;
    vec_in[2]  = 64'h0F1E2D3C4B5A6978; vec_exp[2] = 64'h78695A4B3C2D1E0F;
    sortIn = vec_in[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_%0d", i), sortOut, vec_exp[i]);
      if (i < 2) sortIn = vec_in[i+1];
    end

    // Already-sorted input while data flows, then a reset pulse between edges.
    sortIn = 64'hF0C0804020100801;
    @(posedge clk); #1;
    chk("sorted_pass", sortOut, 64'hF0C0804020100801);
    sortIn = 64'h0102030405060708;
    #1 rst = 1'b1;
    #1;
    chk("midreset_async", sortOut, 64'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_reload", sortOut, 64'h0807060504030201);

    // All lanes at the maximum value.
    sortIn = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    chk("all_max", sortOut, 64'hFFFFFFFFFFFFFFFF);

    // Random sets, each checked one cycle after it is applied.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 8; k++) rnd[k*8 +: 8] = 8'($urandom % 256);
      sortIn = rnd;
      @(posedge clk); #1;
      chk("random", sortOut, sw_sort(rnd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
